uart_vec_bridge: RTL
====================

Name: uart_vec_bridge

Overview:
- Parametrised byte-stream-to-bit-vector bridge between the usb_uart byte pipeline and a combinational design-under-test.
- RX side: decodes command bytes to write individual bits of a drive vector (vec_out), with paging for vectors wider than 64 bits.
- TX side: returns a captured snapshot of the result vector (vec_in) as ASCII '0'/'1' frames ending in a terminator.
- Supports one-shot and continuous streaming modes.

Parameters:
- IN_LEN, 64, width of vec_out (drive vector); legal 1..4096.
- OUT_LEN, 64, width of vec_in (result vector); legal 1..4096.
- END_TOKEN, 8'h2A, frame terminator byte.
- ZERO_CHAR, 8'h30, character sent for a 0 bit; a 1 bit sends ZERO_CHAR+1.

Ports:
- clk_48mhz  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from host (uart_out_data side).
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted on a cycle where rx_valid&&rx_ready.
- tx_data  out  8  byte to host (uart_in_data side).
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts on a cycle where tx_valid&&tx_ready.
- vec_out  out  IN_LEN  registered drive vector.
- vec_in  in  OUT_LEN  result vector; may change any cycle.
- busy  out  1  high while a TX frame is in progress.
- cmd_err  out  1  sticky; set by an out-of-range index or an undefined command.
- rx_seen  out  1  sticky; set on the first accepted byte (LED indicator).

Behaviour:
- Reset (async assert, sync release) values:
  - vec_out=0, page=0, stream_en=0, pending=0, busy=0, tx_valid=0, tx_data=0.
  - cmd_err=0, rx_seen=0, rx_ready=0.
- rx_ready is registered: it goes to 1 on the first clock after reset deasserts and then stays 1. The block never stalls RX, and one byte is consumed per cycle.
- RX decode of an accepted byte b:
  - b[7]=0: bit write. idx = page*64 + b[6:1]. If idx<IN_LEN then vec_out[idx]<=b[0] on the next edge; otherwise there is no write and cmd_err<=1.
  - b[7:6]=2'b10: page <= b[5:0].
  - 8'hC0: request one frame; pending<=1.
  - 8'hC1: stream_en<=1.
  - 8'hC2: stream_en<=0. Any frame in progress completes.
  - 8'hC3: vec_out<=0. page is unchanged.
  - 8'hC4: cmd_err<=0. This clear wins over a set in the same cycle, but a set can only come from the same byte, so the case cannot arise.
  - Any other byte: ignored, cmd_err<=1.
- TX FSM states: IDLE, SEND, TERM.
  - IDLE: if pending||stream_en:
    - snap<=vec_in, cursor<=0, pending<=0, busy<=1.
    - tx_data<=ZERO_CHAR+vec_in[0], tx_valid<=1.
    - Go to SEND.
  - SEND: on accept (tx_valid&&tx_ready):
    - If cursor==OUT_LEN-1: tx_data<=END_TOKEN, go to TERM.
    - Else: cursor+1, tx_data<=ZERO_CHAR+snap[cursor+1].
    - tx_valid stays 1, so there is no bubble between bytes.
  - TERM: on accept:
    - If pending||stream_en: immediately re-snapshot and start the next frame (back-to-back, no idle cycle).
    - Else: tx_valid<=0, busy<=0, go to IDLE.
- tx_data and tx_valid are held stable while tx_valid && !tx_ready.
- Frame = OUT_LEN data bytes, LSB first, then END_TOKEN. The frame reflects vec_in sampled on the single cycle the frame starts; later vec_in changes do not alter that frame.
- 8'hC0 received while busy sets pending, and a further frame follows the current one. Multiple C0s while busy coalesce into one.
- vec_out changes mid-frame do not affect the frame in flight.
- Width rules:
  - cursor width = $clog2(OUT_LEN+1).
  - idx computed at 12+ bits with no truncation. Page values beyond IN_LEN are legal but make every write out of range.
- Reset mid-frame: tx_valid drops asynchronously and the frame is abandoned; no terminator is sent.

Test Plan:
- IN_LEN=64, OUT_LEN=8, vec_in=8'b1010_0011, send 8'hC0 → tx bytes 31 31 30 30 30 31 30 31 2A; busy falls after 2A is accepted; tx_valid low afterwards.
- Send 8'h0B then 8'h7E → vec_out[5]=1 and vec_out[63]=0, each one cycle after its accept; rx_seen=1; cmd_err=0.
- IN_LEN=100: send 8'h81 then 8'h4F (idx 103) → vec_out unchanged, cmd_err=1. Then 8'hC4 → cmd_err=0. Then 8'h49 (idx 100, value 1) → cmd_err=1, no write.
- Streaming: 8'hC1 with tx_ready tied high → continuous frames with 2A every OUT_LEN+1 bytes and no tx_valid gap. Toggle vec_in mid-frame → the change appears only in the next frame. Send 8'hC2 → the current frame ends, then tx_valid=0.
- Backpressure: tx_ready low for 5 cycles mid-frame → tx_data/tx_valid stable throughout; the byte sequence is unchanged. C0 sent twice while busy → exactly one extra frame.
- Assert reset during SEND → tx_valid=0 and vec_out=0 immediately (asynchronous). After release, rx_ready=1 next cycle, no frame until C0 is received.

Source files
------------

// File: rtl/uart_vec_bridge_if.sv
// ============================================================================
// Module  : uart_vec_bridge_if
// Brief   : Byte-stream handshake bundle between the usb_uart pipeline and
//           uart_vec_bridge (RX bytes from host, TX bytes to host).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_vec_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

`default_nettype wire

// File: rtl/uart_vec_bridge.sv
// ============================================================================
// Module  : uart_vec_bridge
// Brief   : Byte-command bridge that drives a bit vector and returns ASCII
//           snapshots of a result vector as terminated frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_vec_bridge #(
    parameter int         IN_LEN    = 64,
    parameter int         OUT_LEN   = 64,
    parameter logic [7:0] END_TOKEN = 8'h2A,
    parameter logic [7:0] ZERO_CHAR = 8'h30
) (
    input  wire logic               clk_48mhz,
    input  wire logic               reset,
    uart_vec_bridge_if.slave        uart,
    output logic [IN_LEN-1:0]       vec_out,
    input  wire logic [OUT_LEN-1:0] vec_in,
    output logic                    busy,
    output logic                    cmd_err,
    output logic                    rx_seen
);

    localparam int                 C_CUR_W = $clog2(OUT_LEN + 1);
    localparam logic [C_CUR_W-1:0] C_LAST  = C_CUR_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TERM = 2'd2
    } state_t;

    state_t               r_state;
    logic [IN_LEN-1:0]    r_vec_out;
    logic [5:0]           r_page;
    logic                 r_stream_en;
    logic                 r_pending;
    logic                 r_busy;
    logic                 r_cmd_err;
    logic                 r_rx_seen;
    logic                 r_rx_ready;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_data;
    logic [OUT_LEN-1:0]   r_snap;
    logic [C_CUR_W-1:0]   r_cursor;

    logic                 w_rx_fire;
    logic                 w_tx_fire;
    logic                 w_req_frame;
    logic                 w_start;
    logic [12:0]          w_idx;
    logic                 w_idx_ok;
    logic [OUT_LEN-1:0]   w_snap_nxt;

    function automatic logic [7:0] bit_char(input logic b);
        return ZERO_CHAR + {7'd0, b};
    endfunction

    assign w_rx_fire   = uart.rx_valid && r_rx_ready;
    assign w_tx_fire   = r_tx_valid && uart.tx_ready;
    assign w_req_frame = w_rx_fire && (uart.rx_data == 8'hC0);
    assign w_idx       = {1'b0, r_page, uart.rx_data[6:1]};
    assign w_idx_ok    = (w_idx < 13'(IN_LEN));
    assign w_snap_nxt  = r_snap >> 1;

    // A frame starts from idle, or directly off the terminator accept so
    // consecutive frames run without an idle cycle.
    assign w_start = (r_pending || r_stream_en) &&
                     ((r_state == ST_IDLE) || ((r_state == ST_TERM) && w_tx_fire));

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_rx_ready  <= 1'b0;
            r_rx_seen   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_vec_out   <= '0;
            r_page      <= 6'd0;
            r_stream_en <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            if (w_rx_fire) begin
                r_rx_seen <= 1'b1;
                if (!uart.rx_data[7]) begin
                    if (w_idx_ok) begin
                        for (int i = 0; i < IN_LEN; i++) begin
                            if (w_idx == 13'(i)) begin
                                r_vec_out[i] <= uart.rx_data[0];
                            end
                        end
                    end else begin
                        r_cmd_err <= 1'b1;
                    end
                end else if (!uart.rx_data[6]) begin
                    r_page <= uart.rx_data[5:0];
                end else begin
                    case (uart.rx_data)
                        8'hC0:   ;
                        8'hC1:   r_stream_en <= 1'b1;
                        8'hC2:   r_stream_en <= 1'b0;
                        8'hC3:   r_vec_out   <= '0;
                        8'hC4:   r_cmd_err   <= 1'b0;
                        default: r_cmd_err   <= 1'b1;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_cursor   <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            if (w_start) begin
                r_snap     <= vec_in;
                r_cursor   <= '0;
                r_pending  <= 1'b0;
                r_busy     <= 1'b1;
                r_tx_data  <= bit_char(vec_in[0]);
                r_tx_valid <= 1'b1;
                r_state    <= ST_SEND;
            end else begin
                case (r_state)
                    ST_SEND: begin
                        if (w_tx_fire) begin
                            if (r_cursor == C_LAST) begin
                                r_tx_data <= END_TOKEN;
                                r_state   <= ST_TERM;
                            end else begin
                                r_cursor  <= r_cursor + 1'b1;
                                r_snap    <= w_snap_nxt;
                                r_tx_data <= bit_char(w_snap_nxt[0]);
                            end
                        end
                    end
                    ST_TERM: begin
                        if (w_tx_fire) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            // A request landing on a frame-start edge is kept for a later frame.
            if (w_req_frame) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign uart.rx_ready = r_rx_ready;
    assign uart.tx_data  = r_tx_data;
    assign uart.tx_valid = r_tx_valid;
    assign vec_out       = r_vec_out;
    assign busy          = r_busy;
    assign cmd_err       = r_cmd_err;
    assign rx_seen       = r_rx_seen;

endmodule

`default_nettype wire
